// File: rtl/bmp_ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bmp_ram_arbiter_pkg
// Shared definitions for the BMP frame RAM arbiter and its helpers:
//   - arb_state_e    : arbiter FSM states (ARB = no owner, OWN = port owned)
//   - DEF_BYTE_WIDTH : default RAM data width
//   - DEF_ADDR_WIDTH : default RAM address width
// -----------------------------------------------------------------------------
package bmp_ram_arbiter_pkg;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_e;

    localparam int DEF_BYTE_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 20;

endpackage

// File: rtl/bmp_ram_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. Starting at ptr_i and moving
// upward with wrap-around, returns the first requester whose request is high.
// Ports:
//   req_i   : request vector, one bit per requester
//   ptr_i   : index that has highest priority this time
//   found_o : at least one request is high
//   idx_o   : index of the selected requester (0 when found_o is low)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Scan from the farthest candidate back toward ptr_i, so the last hit
        // written is the one nearest to ptr_i.
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/bmp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// bmp_ram_arbiter
// Shares the single-port byte-wide BMP frame RAM between image-processing
// stages. One requester owns the port at a time (round-robin, optional burst
// lock, burst length capped at MAX_BURST). The owner's accesses are forwarded
// to the RAM; read data returns one cycle later tagged to the requester that
// issued the read.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req/lock/we: per-requester request, keep-ownership, write select
//   addr/wdata : per-requester address and write data (packed, slice i)
//   gnt        : one-hot current owner
//   ack        : access accepted this cycle
//   rvalid     : read data valid for requester i
//   rdata      : shared read data (0 unless some rvalid is high)
//   RAM_*      : RAM port (RAM_out is read data, one cycle after RAM_ren)
//   busy       : an owner exists or a read is still returning
// -----------------------------------------------------------------------------
module bmp_ram_arbiter
    import bmp_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_BURST  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*BYTE_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [BYTE_WIDTH-1:0]         rdata,
    output logic                          RAM_ren,
    output logic                          RAM_wen,
    output logic [ADDR_WIDTH-1:0]         RAM_addr,
    output logic [BYTE_WIDTH-1:0]         RAM_in,
    input  logic [BYTE_WIDTH-1:0]         RAM_out,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q;
    logic [CNT_W-1:0] burst_cnt_d;
    logic             rd_pend_q;
    logic [IDX_W-1:0] rd_tag_q;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    logic                  owned;
    logic                  own_req;
    logic                  own_lock;
    logic                  own_we;
    logic                  access;
    logic                  release_c;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [BYTE_WIDTH-1:0] own_wdata;
    logic [NUM_REQ-1:0]    own_onehot;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Owner's view of the shared input vectors.
    assign owned      = (state_q == OWN);
    assign own_req    = req[owner_q];
    assign own_lock   = lock[owner_q];
    assign own_we     = we[owner_q];
    assign own_addr   = addr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign own_wdata  = wdata[owner_q*BYTE_WIDTH +: BYTE_WIDTH];
    assign own_onehot = NUM_REQ'(1) << owner_q;
    assign access     = owned & own_req;

    assign burst_cnt_d = burst_cnt_q + CNT_W'(1);
    assign rr_ptr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    // An accepted access releases unless locked and under the burst cap;
    // an idle owner releases only once its lock is dropped.
    assign release_c = owned &
                       ((own_req & (~own_lock | (burst_cnt_d == CNT_W'(MAX_BURST)))) |
                        (~own_req & ~own_lock));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (pick_found) begin
                        owner_q     <= pick_idx;
                        burst_cnt_q <= '0;
                        state_q     <= OWN;
                    end
                end
                OWN: begin
                    if (own_req) begin
                        burst_cnt_q <= burst_cnt_d;
                    end
                    if (release_c) begin
                        state_q  <= ARB;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // Read return runs independently of the FSM so a read accepted in the
    // release cycle still comes back after ownership has moved on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_tag_q  <= '0;
        end else begin
            rd_pend_q <= access & ~own_we;
            rd_tag_q  <= owner_q;
        end
    end

    assign gnt      = owned ? own_onehot : '0;
    assign ack      = access ? own_onehot : '0;
    assign rvalid   = rd_pend_q ? (NUM_REQ'(1) << rd_tag_q) : '0;
    assign rdata    = rd_pend_q ? RAM_out : '0;
    assign RAM_ren  = access & ~own_we;
    assign RAM_wen  = access & own_we;
    assign RAM_addr = owned ? own_addr : '0;
    assign RAM_in   = owned ? own_wdata : '0;
    assign busy     = owned | rd_pend_q;

endmodule

// File: tb/tb_bmp_ram_arbiter.sv
module tb_bmp_ram_arbiter;

    localparam int N3  = 3;
    localparam int MB3 = 4;
    localparam int RND_CYCLES = 1500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main instance: 2 requesters, MAX_BURST 64 ----------------
    logic [1:0]  req, lock, we;
    logic [19:0] a0, a1;
    logic [7:0]  wd0, wd1;
    logic [39:0] addr;
    logic [15:0] wdata;
    logic [1:0]  gnt, ack, rvalid;
    logic [7:0]  rdata;
    logic        RAM_ren, RAM_wen;
    logic [19:0] RAM_addr;
    logic [7:0]  RAM_in, RAM_out;
    logic        busy;

    assign addr  = {a1, a0};
    assign wdata = {wd1, wd0};

    bmp_ram_arbiter #(.NUM_REQ(2), .BYTE_WIDTH(8), .ADDR_WIDTH(20), .MAX_BURST(64)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rvalid(rvalid), .rdata(rdata),
        .RAM_ren(RAM_ren), .RAM_wen(RAM_wen), .RAM_addr(RAM_addr), .RAM_in(RAM_in),
        .RAM_out(RAM_out), .busy(busy)
    );

    // ---------------- cap instance: 3 requesters, MAX_BURST 4 ----------------
    logic [2:0]  req3, lock3, we3;
    logic [19:0] r_addr [N3];
    logic [7:0]  r_wd   [N3];
    logic [59:0] addr3;
    logic [23:0] wdata3;
    logic [2:0]  gnt3, ack3, rvalid3;
    logic [7:0]  rdata3;
    logic        ren3, wen3;
    logic [19:0] raddr3;
    logic [7:0]  rin3, rout3;
    logic        busy3;

    always_comb begin
        addr3  = '0;
        wdata3 = '0;
        for (int i = 0; i < N3; i++) begin
            addr3[i*20 +: 20] = r_addr[i];
            wdata3[i*8 +: 8]  = r_wd[i];
        end
    end

    bmp_ram_arbiter #(.NUM_REQ(N3), .BYTE_WIDTH(8), .ADDR_WIDTH(20), .MAX_BURST(MB3)) dut_cap (
        .clk(clk), .rst(rst), .req(req3), .lock(lock3), .we(we3), .addr(addr3), .wdata(wdata3),
        .gnt(gnt3), .ack(ack3), .rvalid(rvalid3), .rdata(rdata3),
        .RAM_ren(ren3), .RAM_wen(wen3), .RAM_addr(raddr3), .RAM_in(rin3),
        .RAM_out(rout3), .busy(busy3)
    );

    // ---------------- RAM models (contents re-seeded on reset) ----------------
    logic [7:0] mem  [256];
    logic [7:0] mem3 [256];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hB6;
            RAM_out <= '0;
        end else begin
            if (RAM_wen) mem[RAM_addr[7:0]] <= RAM_in;
            if (RAM_ren) RAM_out <= mem[RAM_addr[7:0]];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 8'(i) ^ 8'hB6;
            rout3 <= '0;
        end else begin
            if (wen3) mem3[raddr3[7:0]] <= rin3;
            if (ren3) rout3 <= mem3[raddr3[7:0]];
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; lock = '0; we = '0; a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;
        req3 = '0; lock3 = '0; we3 = '0;
        for (int i = 0; i < N3; i++) begin
            r_addr[i] = '0;
            r_wd[i]   = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- vector table for the main instance ----------------
    typedef struct {
        logic       rb;
        logic [1:0] req, lock, we;
        logic [7:0] a0, a1, wd0, wd1;
        logic [1:0] e_gnt, e_ack, e_rv;
        logic       e_ren, e_wen;
        logic [7:0] e_addr, e_wd, e_rd;
        logic       e_busy;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    // ---------------- reference model for the cap instance ----------------
    int         m_own, m_rr, m_cnt, m_ptag;
    bit         m_pv;
    logic [7:0] m_pdata;
    logic [7:0] mmem [256];
    logic [2:0] e_gnt3, e_ack3, e_rv3;
    logic [7:0] e_rd3, e_in3;
    logic [19:0] e_addr3;
    logic       e_ren3, e_wen3, e_busy3;

    task automatic model_eval();
        e_gnt3 = '0; e_ack3 = '0; e_ren3 = 0; e_wen3 = 0; e_addr3 = '0; e_in3 = '0;
        e_rv3  = m_pv ? 3'(1 << m_ptag) : 3'b000;
        e_rd3  = m_pv ? m_pdata : 8'h00;
        e_busy3 = (m_own >= 0) || m_pv;
        if (m_own >= 0) begin
            e_gnt3  = 3'(1 << m_own);
            e_addr3 = r_addr[m_own];
            e_in3   = r_wd[m_own];
            if (req3[m_own]) begin
                e_ack3 = 3'(1 << m_own);
                if (we3[m_own]) e_wen3 = 1; else e_ren3 = 1;
            end
        end
    endtask

    task automatic model_update();
        int o;
        bit nv;
        int ntag;
        logic [7:0] ndata;
        o = m_own; nv = 0; ntag = 0; ndata = '0;
        if (o >= 0) begin
            if (req3[o]) begin
                if (we3[o]) mmem[r_addr[o][7:0]] = r_wd[o];
                else begin
                    nv = 1; ntag = o; ndata = mmem[r_addr[o][7:0]];
                end
                m_cnt++;
                if (!lock3[o] || m_cnt == MB3) begin
                    m_rr = (o + 1) % N3; m_own = -1;
                end
            end else if (!lock3[o]) begin
                m_rr = (o + 1) % N3; m_own = -1;
            end
        end else begin
            for (int k = 0; k < N3; k++)
                if (m_own < 0 && req3[(m_rr + k) % N3]) begin
                    m_own = (m_rr + k) % N3; m_cnt = 0;
                end
        end
        m_pv = nv; m_ptag = ntag; m_pdata = ndata;
    endtask

    int n0;

    initial begin
        tbl[0]  = '{1'b1, 2'b01, 2'b00, 2'b00, 8'h36, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 2'b01, 2'b00, 2'b00, 8'h36, 8'h00, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 8'h36, 8'h00, 8'h00, 1'b1};
        tbl[2]  = '{1'b0, 2'b00, 2'b00, 2'b00, 8'h36, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 8'h80, 1'b1};
        tbl[3]  = '{1'b0, 2'b00, 2'b00, 2'b00, 8'h36, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 2'b11, 2'b00, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 2'b11, 2'b00, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 8'h10, 8'h11, 8'h00, 1'b1};
        tbl[6]  = '{1'b0, 2'b11, 2'b00, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 2'b11, 2'b00, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 8'h20, 8'h22, 8'h00, 1'b1};
        tbl[8]  = '{1'b0, 2'b11, 2'b00, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 2'b11, 2'b00, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 8'h10, 8'h11, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 2'b11, 2'b00, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 2'b11, 2'b00, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 8'h20, 8'h22, 8'h00, 1'b1};

        idle_inputs();

        // Reset state, sampled while reset is held.
        @(negedge clk);
        chk("rst_gnt", gnt, 0);     chk("rst_ack", ack, 0);     chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0); chk("rst_ren", RAM_ren, 0); chk("rst_wen", RAM_wen, 0);
        chk("rst_addr", RAM_addr, 0); chk("rst_in", RAM_in, 0); chk("rst_busy", busy, 0);
        chk("rst_gnt3", gnt3, 0);   chk("rst_busy3", busy3, 0);
        do_reset();

        // Single read and two-way contention.
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rb) do_reset();
            req = tbl[i].req; lock = tbl[i].lock; we = tbl[i].we;
            a0 = 20'(tbl[i].a0); a1 = 20'(tbl[i].a1); wd0 = tbl[i].wd0; wd1 = tbl[i].wd1;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), gnt, tbl[i].e_gnt);
            chk($sformatf("v%0d_ack", i), ack, tbl[i].e_ack);
            chk($sformatf("v%0d_rvalid", i), rvalid, tbl[i].e_rv);
            chk($sformatf("v%0d_ren", i), RAM_ren, tbl[i].e_ren);
            chk($sformatf("v%0d_wen", i), RAM_wen, tbl[i].e_wen);
            chk($sformatf("v%0d_addr", i), RAM_addr, 20'(tbl[i].e_addr));
            chk($sformatf("v%0d_in", i), RAM_in, tbl[i].e_wd);
            chk($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rd);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            step();
        end

        // Locked burst of 5 writes by requester 1 while requester 0 waits.
        do_reset();
        req = 2'b01; we = 2'b01; a0 = 20'h50; wd0 = 8'h01;
        step();
        step();
        req = 2'b11; lock = 2'b10; we = 2'b11; a1 = 20'h40; wd1 = 8'hFF;
        step();
        for (int i = 0; i < 5; i++) begin
            a1 = 20'h40 + 20'(i);
            lock = {(i < 4), 1'b0};
            @(negedge clk);
            chk($sformatf("burst%0d_gnt", i), gnt, 2'b10);
            chk($sformatf("burst%0d_ack", i), ack, 2'b10);
            chk($sformatf("burst%0d_wen", i), RAM_wen, 1);
            chk($sformatf("burst%0d_in", i), RAM_in, 8'hFF);
            chk($sformatf("burst%0d_addr", i), RAM_addr, 20'h40 + 20'(i));
            step();
        end
        req = 2'b01; lock = 2'b00;
        @(negedge clk);
        chk("burst_bubble_gnt", gnt, 2'b00);
        step();
        @(negedge clk);
        chk("burst_next_gnt", gnt, 2'b01);
        chk("burst_next_ack", ack, 2'b01);
        step();

        // Starvation cap: requester 0 locked and continuous, requester 1 pending.
        do_reset();
        req3 = 3'b011; lock3 = 3'b001; we3 = 3'b011; r_addr[0] = 20'h1; r_addr[1] = 20'h2;
        @(negedge clk);
        chk("cap_arb_gnt", gnt3, 3'b000);
        step();
        n0 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack3[0]) n0++;
            step();
        end
        chk("cap_acks0", n0, 4);
        @(negedge clk);
        chk("cap_gnt1", gnt3, 3'b010);
        chk("cap_ack1", ack3, 3'b010);
        step();

        // Lock hold: two acks, three idle locked cycles, two more acks.
        do_reset();
        req3 = 3'b001; lock3 = 3'b001; we3 = 3'b001;
        step();
        for (int i = 0; i < 7; i++) begin
            req3 = (i >= 2 && i <= 4) ? 3'b000 : 3'b001;
            @(negedge clk);
            chk($sformatf("hold%0d_gnt", i), gnt3, 3'b001);
            chk($sformatf("hold%0d_ack", i), ack3, (i >= 2 && i <= 4) ? 3'b000 : 3'b001);
            if (i == 6) i = 7;
            else step();
        end
        step();
        @(negedge clk);
        chk("hold_cap_release", gnt3, 3'b000);
        step();

        // Owner drops req and lock together.
        do_reset();
        req = 2'b01; lock = 2'b01; we = 2'b01;
        step();
        @(negedge clk);
        chk("drop_ack", ack, 2'b01);
        step();
        req = 2'b00; lock = 2'b00;
        @(negedge clk);
        chk("drop_gnt_held", gnt, 2'b01);
        chk("drop_no_ack", ack, 2'b00);
        step();
        @(negedge clk);
        chk("drop_arb_gnt", gnt, 2'b00);
        chk("drop_arb_busy", busy, 0);
        step();

        // Reset during a locked read burst by requester 1.
        do_reset();
        req = 2'b01; we = 2'b00;
        step();
        step();
        req = 2'b10; lock = 2'b10; a1 = 20'h36; wd1 = 8'h77;
        step();
        @(negedge clk);
        chk("mid_ack_a", ack, 2'b10);
        step();
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mid_gnt", gnt, 0);     chk("mid_ack", ack, 0);     chk("mid_rvalid", rvalid, 0);
        chk("mid_rdata", rdata, 0); chk("mid_ren", RAM_ren, 0); chk("mid_wen", RAM_wen, 0);
        chk("mid_addr", RAM_addr, 0); chk("mid_in", RAM_in, 0); chk("mid_busy", busy, 0);
        step();
        @(negedge clk);
        chk("mid_rvalid_lost", rvalid, 0);
        step();
        rst = 1'b0;
        req = 2'b11; lock = 2'b00;
        step();
        @(negedge clk);
        chk("mid_first_gnt", gnt, 2'b01);
        step();

        // Randomized traffic on the 3-requester instance against the model.
        do_reset();
        m_own = -1; m_rr = 0; m_cnt = 0; m_pv = 0; m_ptag = 0; m_pdata = '0;
        for (int i = 0; i < 256; i++) mmem[i] = 8'(i) ^ 8'hB6;
        for (int c = 0; c < RND_CYCLES; c++) begin
            @(negedge clk);
            model_eval();
            chk("rnd_gnt", gnt3, e_gnt3);   chk("rnd_ack", ack3, e_ack3);
            chk("rnd_rvalid", rvalid3, e_rv3); chk("rnd_rdata", rdata3, e_rd3);
            chk("rnd_ren", ren3, e_ren3);   chk("rnd_wen", wen3, e_wen3);
            chk("rnd_addr", raddr3, e_addr3); chk("rnd_in", rin3, e_in3);
            chk("rnd_busy", busy3, e_busy3);
            model_update();
            step();
            for (int i = 0; i < N3; i++) begin
                if (!req3[i] || e_ack3[i]) begin
                    if ($urandom_range(0, 99) < 55) begin
                        req3[i]   = 1'b1;
                        we3[i]    = 1'($urandom_range(0, 1));
                        r_addr[i] = 20'($urandom_range(0, 15));
                        r_wd[i]   = 8'($urandom);
                    end else begin
                        req3[i] = 1'b0;
                    end
                end
                lock3[i] = ($urandom_range(0, 99) < 65);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bmp_ram_arbiter.md
# bmp_ram_arbiter

Shares the single-port byte-wide BMP frame RAM between the image-processing stages (grayscale, binarization, and later stages) so they no longer drive the RAM port directly. Each stage becomes a requester. The block grants the port to one requester at a time using round-robin with optional burst locking and a starvation cap. It forwards the owner's accesses to the RAM and routes one-cycle-latency read data back to the owner.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, from 2 to 8.
- BYTE_WIDTH, 8: RAM data width.
- ADDR_WIDTH, 20: RAM address width.
- MAX_BURST, 64: maximum accepted accesses per grant; must be at least 1.

Ports (vectors below are packed per requester, requester i in slice i):
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; one clock, asynchronous, active-high.
- req  in  NUM_REQ  access request, held until acked.
- lock  in  NUM_REQ  keep ownership after the current access.
- we  in  NUM_REQ  1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_WIDTH  access address.
- wdata  in  NUM_REQ*BYTE_WIDTH  write data.
- gnt  out  NUM_REQ  one-hot ownership; all zero when no owner.
- ack  out  NUM_REQ  access accepted this cycle.
- rvalid  out  NUM_REQ  read data valid for requester i.
- rdata  out  BYTE_WIDTH  read data, shared by all requesters; qualify with rvalid.
- RAM_ren  out  1  RAM read enable.
- RAM_wen  out  1  RAM write enable.
- RAM_addr  out  ADDR_WIDTH  RAM address.
- RAM_in  out  BYTE_WIDTH  RAM write data.
- RAM_out  in  BYTE_WIDTH  RAM read data, valid one cycle after RAM_ren.
- busy  out  1  an owner exists or a read is pending.

## Operation
- FSM states:
  - ARB: no owner; gnt = 0.
    - If any req is high, choose the first requester whose req is high, searching from rr_ptr upward with wrap.
    - Load that requester into owner, clear burst_cnt, and go to OWN.
    - If no req is high, stay in ARB.
  - OWN: gnt = onehot(owner). Release means: go to ARB and set rr_ptr = (owner+1) mod NUM_REQ.
    - When req[owner] is high: ack[owner] = 1 and burst_cnt increments. Release if lock[owner] = 0, or if the incremented count equals MAX_BURST; otherwise stay.
    - When req[owner] is low and lock[owner] is low: release with no access.
    - When req[owner] is low and lock[owner] is high: hold ownership and do not count.
- RAM port is combinational from the owner register and the owner's inputs:
  - RAM_ren = ack & ~we[owner].
  - RAM_wen = ack & we[owner].
  - RAM_addr and RAM_in mux the owner's slices; they are 0 when there is no owner.
- Read return:
  - Registered rd_pend and rd_tag capture read acks.
  - Next cycle: rvalid[rd_tag] = 1 and rdata = RAM_out; otherwise rdata = 0.
  - rd_pend is independent of the FSM, so a read accepted in the release cycle still returns after ownership moves.
- Requesters not granted see ack = 0 and must hold req, we, addr and wdata stable.
- burst_cnt width is clog2(MAX_BURST+1). It never wraps, because release happens at MAX_BURST.
- rr_ptr resets to 0, so requester 0 has priority on the first arbitration.

## Timing
- Reset values:
  - state ARB, owner 0, rr_ptr 0, burst_cnt 0, rd_pend 0.
  - All outputs 0: gnt, ack, rvalid, rdata, RAM_*, busy.
- Reset mid-burst: ownership, counter and pending read are dropped immediately. A pending read's rvalid is lost; requesters restart after reset.
- Grant latency: req rises in cycle 0 while in ARB; gnt and ack can be high in cycle 1.
- Read latency: ack in cycle n, rvalid in cycle n+1.
- Throughput:
  - Locked burst: one access per cycle.
  - Unlocked: one access, then one ARB bubble. The next grant is two cycles after the ack, so peak throughput is 1 access per 2 cycles.
- Simultaneous requests: the winner is decided purely by rr_ptr order. The others wait at least until the owner releases plus one ARB cycle.
- Owner drops req and lock together: release that cycle, ARB the next cycle.
- busy = (state == OWN) | rd_pend.

## Structure
- Shared package/header alongside DEFINE.vh: the FSM state encodings ARB and OWN, and the default BYTE_WIDTH/ADDR_WIDTH values.
- Sub-module rr_pick: combinational round-robin priority encoder (req vector, rr_ptr) -> (found, index). It is instantiated once and reusable by later schedulers.
- The remainder is a single module: FSM, burst counter, input muxes and read-return register.

## Test plan
- Single read: NUM_REQ=2, req[0] reads addr 0x36 holding 0x80.
  - Required: gnt[0] and ack[0] in cycle 1, RAM_ren=1 with RAM_addr=0x36.
  - Required: rvalid[0]=1 and rdata=0x80 in cycle 2, then gnt returns to 0.
- Contention: req[0] and req[1] rise together from reset, unlocked.
  - Required: grants in the order 0, 1, 0, 1, with one ARB cycle between each.
- Locked burst: req[1] locked for 5 writes with data 0xFF while req[0] waits.
  - Required: 5 consecutive RAM_wen cycles, then release with gnt[0] two cycles after the last ack.
- Starvation cap: MAX_BURST=4, req[0] locked and continuous, req[1] pending.
  - Required: exactly 4 acks to requester 0, then requester 1 is granted.
- Lock hold: the owner drops req for 3 cycles with lock high, then resumes.
  - Required: gnt is held throughout and burst_cnt is unchanged.
  - Then the owner drops both req and lock: ARB the next cycle.
- Reset mid-burst: assert rst during a locked read.
  - Required: all outputs 0 the same cycle, no rvalid, and requester 0 wins the first grant after reset.
